// File: rtl/shared_reg_rr_arbiter_if.sv
// shared_reg_rr_arbiter_if: requester-side bus of the shared register arbiter
interface shared_reg_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = $clog2(N);
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [IW-1:0]  owner;
  logic           busy;
  modport master (output req, din, input gnt, ack, q, q_valid, owner, busy);
  modport slave  (input req, din, output gnt, ack, q, q_valid, owner, busy);
endinterface

// File: rtl/shared_reg_rr_arbiter.sv
// shared_reg_rr_arbiter: round-robin write sequencer for one shared register
module shared_reg_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  shared_reg_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, sel_q, sel_d, owner_q, owner_d, win;
  logic [N-1:0]  gnt_q, gnt_d, ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;
  // descending scan so the candidate closest to ptr is assigned last and wins
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (bus.req[(int'(ptr_q) + k) % N]) win = IW'((int'(ptr_q) + k) % N);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = '0;
    ack_d     = '0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = GRANT;
        sel_d   = win;
        gnt_d   = N'(1) << win;
      end
    end else begin
      state_d = IDLE;
      if (bus.req[sel_q]) begin
        q_d       = bus.din[sel_q*W +: W];
        owner_d   = sel_q;
        q_valid_d = 1'b1;
        ack_d     = N'(1) << sel_q;
        ptr_d     = (sel_q == IW'(N - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end
  always_comb begin
    bus.gnt     = gnt_q;
    bus.ack     = ack_q;
    bus.q       = q_q;
    bus.q_valid = q_valid_q;
    bus.owner   = owner_q;
    bus.busy    = state_q == GRANT;
  end
endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// tb_shared_reg_rr_arbiter: directed scenarios plus randomized run against a reference model
module tb_shared_reg_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  shared_reg_rr_arbiter_if #(.N(N), .W(W)) bus ();
  shared_reg_rr_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req = '0;
    bus.din = '0;
    repeat (3) tick();
    checks++;
    if ({bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy} !== '0) begin
      fails++;
      $display("FAIL reset gnt=%b ack=%b q=%h qv=%b owner=%0d busy=%b exp all zero",
               bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bus.req = 4'b0001;
    bus.din[0 +: W] = 8'hA5;
    tick();
    checks++;
    if ({bus.gnt, bus.busy, bus.ack} !== {4'b0001, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL single_grant gnt=%b busy=%b ack=%b exp 0001 1 0000", bus.gnt, bus.busy, bus.ack);
    end
    tick();
    bus.req = '0;
    checks++;
    if ({bus.q, bus.ack, bus.owner, bus.q_valid, bus.busy, bus.gnt} !== {8'hA5, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000}) begin
      fails++;
      $display("FAIL single_write q=%h ack=%b owner=%0d qv=%b busy=%b gnt=%b exp a5 0001 0 1 0 0000",
               bus.q, bus.ack, bus.owner, bus.q_valid, bus.busy, bus.gnt);
    end
    tick();
  endtask

  task automatic test_all_four;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bus.din[i*W +: W] = 8'(8'h10 + i);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'(1 << (k % N))) begin
        fails++;
        $display("FAIL rr_gnt[%0d] gnt=%b exp %b", k, bus.gnt, 4'(1 << (k % N)));
      end
      tick();
      checks++;
      if ({bus.q, bus.ack} !== {8'(8'h10 + k % N), 4'(1 << (k % N))}) begin
        fails++;
        $display("FAIL rr_write[%0d] q=%h ack=%b exp %h %b", k, bus.q, bus.ack, 8'(8'h10 + k % N), 4'(1 << (k % N)));
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_wrap;
    bus.req = 4'b1000;
    tick();
    tick();
    bus.req = 4'b1010;
    checks++;
    if (bus.ack !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_prewrite ack=%b exp 1000", bus.ack);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL wrap_gnt gnt=%b exp 0010", bus.gnt);
    end
    tick();
    bus.req = '0;
    tick();
  endtask

  task automatic test_withdraw;
    logic [W-1:0] q_before;
    q_before = bus.q;
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    checks++;
    if (bus.gnt !== 4'b0100) begin
      fails++;
      $display("FAIL withdraw_gnt gnt=%b exp 0100", bus.gnt);
    end
    tick();
    checks++;
    if ({bus.q, bus.ack} !== {q_before, 4'b0000}) begin
      fails++;
      $display("FAIL withdraw_abort q=%h ack=%b exp %h 0000", bus.q, bus.ack, q_before);
    end
    bus.req = 4'b0110;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      fails++;
      $display("FAIL withdraw_ptr gnt=%b exp 0100", bus.gnt);
    end
    tick();
    bus.req = '0;
    checks++;
    if ({bus.q, bus.ack} !== {8'h12, 4'b0100}) begin
      fails++;
      $display("FAIL withdraw_regrant q=%h ack=%b exp 12 0100", bus.q, bus.ack);
    end
    tick();
  endtask

  task automatic test_async_reset;
    bus.req = 4'b0010;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL areset_pregnt gnt=%b exp 0010", bus.gnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy} !== '0) begin
      fails++;
      $display("FAIL areset_now gnt=%b ack=%b q=%h qv=%b owner=%0d busy=%b exp all zero",
               bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy);
    end
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL areset_first gnt=%b exp 0001", bus.gnt);
    end
    tick();
    bus.req = '0;
    tick();
  endtask

  task automatic test_late_data;
    bus.din[1*W +: W] = 8'h22;
    bus.req = 4'b0010;
    tick();
    bus.din[1*W +: W] = 8'h33;
    tick();
    bus.req = '0;
    checks++;
    if ({bus.q, bus.ack, bus.owner} !== {8'h33, 4'b0010, 2'd1}) begin
      fails++;
      $display("FAIL late_data q=%h ack=%b owner=%0d exp 33 0010 1", bus.q, bus.ack, bus.owner);
    end
    tick();
  endtask

  task automatic test_random;
    int g, ptr, mown, w;
    logic [W-1:0] mq;
    logic mqv;
    logic [N-1:0] r, mgnt, mack;
    logic [N*W-1:0] d;
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    g = -1; ptr = 0; mown = 0; mq = '0; mqv = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      d = ($urandom_range(0, 1) == 0) ? bus.din : (N*W)'($urandom);
      bus.req = r;
      bus.din = d;
      tick();
      mgnt = '0;
      mack = '0;
      if (g < 0) begin
        if (r != 0) begin
          w = -1;
          for (int k = 0; k < N; k++) if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
          g = w;
          mgnt[w] = 1'b1;
        end
      end else begin
        if (r[g]) begin
          mq = d[g*W +: W];
          mown = g;
          mqv = 1'b1;
          mack[g] = 1'b1;
          ptr = (g + 1) % N;
        end
        g = -1;
      end
      checks++;
      if ({bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy} !== {mgnt, mack, mq, mqv, 2'(mown), g >= 0}) begin
        fails++;
        $display("FAIL random[%0d] gnt=%b ack=%b q=%h qv=%b owner=%0d busy=%b exp %b %b %h %b %0d %b",
                 c, bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy,
                 mgnt, mack, mq, mqv, mown, g >= 0);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_withdraw();
    test_async_reset();
    test_late_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/shared_reg_rr_arbiter.md
Name: shared_reg_rr_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared W-bit D-flip-flop register, shared by N requesters.
- Each requester raises req with its data. The block grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle ack.
- Sits between requester logic and the storage flops. It is the only writer of the shared register.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, shared register data width.
- IW, $clog2(N), requester index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester write request; bit i belongs to requester i.
- din  input  N*W  packed write data; requester i drives din[i*W +: W].
- gnt  output  N  one-hot grant, registered.
- ack  output  N  one-hot, one-cycle write-complete pulse, registered.
- q  output  W  shared register contents.
- q_valid  output  1  high once q has been written at least once since reset.
- owner  output  IW  index of the requester that last wrote q.
- busy  output  1  high while the FSM is in GRANT.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0, gnt=0, ack=0, q=0, q_valid=0, owner=0, busy=0.
  - Takes effect immediately. An in-flight grant is dropped with no write and no ack.
- FSM states: IDLE, GRANT.
- IDLE:
  - ack=0.
  - If req==0, remain in IDLE.
  - Otherwise pick winner w: the first set bit of req searching from index ptr upward, wrapping modulo N.
  - On the next edge: gnt <= onehot(w), sel <= w, busy <= 1, state <= GRANT.
- GRANT (exactly one cycle):
  - If req[sel]==1 at the edge:
    - q <= din[sel], owner <= sel, q_valid <= 1.
    - ack <= onehot(sel).
    - ptr <= (sel+1) mod N.
  - If req[sel]==0 at the edge (withdrawn): abort. No write, ack stays 0, ptr unchanged.
  - In both cases: gnt <= 0, busy <= 0, state <= IDLE.
- Latency and throughput:
  - req seen in IDLE → gnt high the next cycle → q updated and ack high the cycle after.
  - 2 cycles per write; at most one write per 2 cycles.
- Handshake rules:
  - Requester holds req and din stable until ack.
  - Requester deasserts req in the cycle ack is observed, or a new request is taken.
  - din is sampled only at the GRANT→IDLE edge. Changes before that edge are allowed and the last value wins.
  - A req bit that stays high after ack is treated as a new request in the following IDLE cycle.
- Fairness:
  - ptr advances past the winner only on a completed write.
  - With all N requesting continuously, order is 0,1,…,N-1,0,… and no requester waits more than N grants.
- Simultaneous events:
  - Multiple req bits in the same cycle are resolved only by the round-robin search.
  - A new req arriving while in GRANT is ignored until IDLE.
  - A req bit rising in the same cycle ack falls is legal.
- Invariants: gnt and ack are each one-hot or zero. gnt and ack are never nonzero in the same cycle.
- q holds its value indefinitely when no write occurs.

Test Plan:
1. Reset then single requester: N=4, W=8, rst high 3 cycles. Then req=0001, din[0]=8'hA5.
   → gnt=0001 at cycle+1; q=A5, ack=0001, owner=0, q_valid=1 at cycle+2; busy high only at cycle+1.
2. All four request continuously with din[i]=8'h10+i.
   → writes q=10,11,12,13,10 on consecutive alternate cycles; ack order 0001,0010,0100,1000,0001.
3. Pointer wrap: after a write by requester 3 (ptr=0), assert req=1010.
   → requester 1 wins (gnt=0010), not 3.
4. Withdrawal: req=0100 granted, then req[2] dropped during GRANT.
   → q unchanged, ack=0000, ptr unchanged; re-asserting req=0100 is granted again.
5. Async reset mid-GRANT: assert rst between edges while gnt=0010.
   → gnt, ack, q, q_valid, owner, busy go to 0 immediately without a clock; after release, the first winner for req=1111 is requester 0.
6. Late data change: din[1] changes from 8'h22 to 8'h33 during GRANT, before the edge.
   → q=33.
